// File: rtl/exec_sequencer_pkg.sv
// Shared opcode, unit and state definitions for the exec sequencer.
// Imported by the sequencer top and its watchdog.
package exec_sequencer_pkg;

  localparam int TIMEOUT_DEF = 32;
  localparam int NUNITS_DEF  = 4;

  localparam logic [3:0] OP_ALU_RR  = 4'b0000;
  localparam logic [3:0] OP_ALU_IMM = 4'b0001;
  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_PORT    = 4'b0011;

  localparam logic [1:0] U_ALU_RR  = 2'd0;
  localparam logic [1:0] U_ALU_IMM = 2'd1;
  localparam logic [1:0] U_MOVE    = 2'd2;
  localparam logic [1:0] U_PORT    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RETIRE = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [5:0] p1;
    logic [5:0] p2;
  } instr_t;

endpackage

// File: rtl/exec_sequencer_watchdog.sv
// Watchdog for the WAIT state: 8-bit counter with clear/enable
// and a terminal-count flag at TIMEOUT-1.
import exec_sequencer_pkg::*;

module seq_watchdog #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Instruction sequencer: decodes one instruction at a time, hands it
// to one of four execution units and supervises it with a watchdog.
import exec_sequencer_pkg::*;

module exec_sequencer #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int NUNITS  = NUNITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [NUNITS-1:0] unit_start,
  output logic [NUNITS-1:0] unit_abort,
  input  logic [NUNITS-1:0] unit_done,
  output logic [NUNITS-1:0] bus_grant,
  output logic [5:0]        parameter1,
  output logic [5:0]        parameter2,
  output logic              busy,
  output logic              retire,
  output logic              err,
  input  logic              err_clr,
  output logic [7:0]        retired_cnt
);

  state_t            state, state_nxt;
  instr_t            ir;
  logic [1:0]        unit;
  logic [1:0]        dec_unit;
  logic              dec_legal;
  logic [NUNITS-1:0] sel;
  logic [NUNITS-1:0] abort_q;
  logic [7:0]        rcnt;
  logic              accept;
  logic              done_sel;
  logic              drive;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_tc;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  assign sel      = NUNITS'(1) << unit;
  assign done_sel = |(unit_done & sel);
  assign accept   = instr_valid & instr_ready;
  assign drive    = (state == S_ISSUE) |
                    (state == S_WAIT);

  always_comb begin
    dec_unit  = U_ALU_RR;
    dec_legal = 1'b1;
    unique case (1'b1)
      ir.opcode == OP_ALU_RR:  dec_unit = U_ALU_RR;
      ir.opcode == OP_ALU_IMM: dec_unit = U_ALU_IMM;
      ir.opcode == OP_MOVE:    dec_unit = U_MOVE;
      ir.opcode == OP_PORT:    dec_unit = U_PORT;
      default:                 dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = dec_legal ? S_ISSUE : S_ERR;
      end
      S_ISSUE: begin
        wd_clr    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // done beats a same-cycle timeout
        if (done_sel) begin
          state_nxt = S_RETIRE;
        end else if (wd_tc) begin
          state_nxt = S_ERR;
        end else begin
          wd_en = 1'b1;
        end
      end
      S_RETIRE: begin
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      unit    <= U_ALU_RR;
      abort_q <= '0;
      rcnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && accept) begin
        ir <= instr;
      end
      if (state == S_DECODE) begin
        unit <= dec_unit;
      end
      // abort is seen by the unit in the first ERR cycle
      if (state == S_WAIT && !done_sel && wd_tc) begin
        abort_q <= sel;
      end else begin
        abort_q <= '0;
      end
      if (state == S_RETIRE) begin
        rcnt <= rcnt + 8'd1;
      end
    end
  end

  assign err         = (state == S_ERR);
  assign instr_ready = (state == S_IDLE) & ~err;
  assign busy        = (state != S_IDLE);
  assign retire      = (state == S_RETIRE);
  assign unit_start  = drive ? sel : '0;
  assign bus_grant   = drive ? sel : '0;
  assign unit_abort  = abort_q;
  assign parameter1  = ir.p1;
  assign parameter2  = ir.p2;
  assign retired_cnt = rcnt;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised bench for exec_sequencer with a per-instruction
// lifecycle model plus directed literal checks.
module tb_exec_sequencer;

  localparam int TO = 32;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  unit_start;
  logic [3:0]  unit_abort;
  logic [3:0]  unit_done = '0;
  logic [3:0]  bus_grant;
  logic [5:0]  parameter1;
  logic [5:0]  parameter2;
  logic        busy;
  logic        retire;
  logic        err;
  logic        err_clr = 1'b0;
  logic [7:0]  retired_cnt;

  exec_sequencer #(
    .TIMEOUT (TO),
    .NUNITS  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .unit_start  (unit_start),
    .unit_abort  (unit_abort),
    .unit_done   (unit_done),
    .bus_grant   (bus_grant),
    .parameter1  (parameter1),
    .parameter2  (parameter2),
    .busy        (busy),
    .retire      (retire),
    .err         (err),
    .err_clr     (err_clr),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // lifecycle model: phase 0 idle, 1 in flight, 2 retiring, 3 error
  // age counts cycles since accept while in flight
  int         m_phase = 0;
  int         m_age = 0;
  int         m_retired = 0;
  logic       m_abort = 1'b0;
  logic [3:0] m_op = '0;
  logic [5:0] m_p1 = '0;
  logic [5:0] m_p2 = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase   <= 0;
      m_age     <= 0;
      m_retired <= 0;
      m_abort   <= 1'b0;
      m_op      <= '0;
      m_p1      <= '0;
      m_p2      <= '0;
    end else begin
      m_abort <= 1'b0;
      case (m_phase)
        0: if (instr_valid) begin
          m_op    <= instr[15:12];
          m_p1    <= instr[11:6];
          m_p2    <= instr[5:0];
          m_phase <= 1;
          m_age   <= 0;
        end
        1: begin
          if (m_age == 0) begin
            if (m_op > 4'd3) m_phase <= 3;
            else m_age <= 1;
          end else if (m_age == 1) begin
            m_age <= 2;
          end else if (unit_done[m_op[1:0]]) begin
            m_phase <= 2;
          end else if (m_age - 2 == TO - 1) begin
            m_phase <= 3;
            m_abort <= 1'b1;
          end else begin
            m_age <= m_age + 1;
          end
        end
        2: begin
          m_retired <= (m_retired + 1) % 256;
          m_phase   <= 0;
        end
        3: if (err_clr) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // cumulative activity counters sampled each cycle
  int         tot_start = 0;
  int         tot_abort = 0;
  int         tot_retire = 0;
  int         tot_err = 0;
  int         tot_bad = 0;
  logic [3:0] last_start = '0;
  logic [3:0] last_abort = '0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic compare_cycle();
    logic [3:0]  oh;
    logic [3:0]  es;
    logic [3:0]  ea;
    logic [35:0] exp_v;
    logic [35:0] act_v;
    oh = 4'b0001 << m_op[1:0];
    es = (m_phase == 1 && m_age >= 1) ? oh : 4'b0;
    ea = m_abort ? oh : 4'b0;
    exp_v = {m_phase == 0, m_phase != 0, m_phase == 2, m_phase == 3,
             es, es, ea, 8'(m_retired), m_p1, m_p2};
    act_v = {instr_ready, busy, retire, err,
             unit_start, bus_grant, unit_abort, retired_cnt,
             parameter1, parameter2};
    check("cycle_outputs", 64'(act_v), 64'(exp_v));
    tot_start  += (unit_start != 0) ? 1 : 0;
    tot_abort  += (unit_abort != 0) ? 1 : 0;
    tot_retire += retire ? 1 : 0;
    tot_err    += err ? 1 : 0;
    tot_bad    += (unit_abort != 0 && unit_start != 0) ? 1 : 0;
    if (unit_start != 0) last_start = unit_start;
    if (unit_abort != 0) last_abort = unit_abort;
  endtask

  // lat: unit done raised lat cycles after the ISSUE cycle
  task automatic do_instr(input logic [15:0] ins, input int lat,
                          input bit noise);
    int k;
    int guard;
    int ew;
    int cd;
    logic [3:0] sel;
    sel = 4'b0001 << ins[13:12];
    cd = $urandom_range(0, 3);
    instr_valid = 1'b1;
    instr = ins;
    unit_done = '0;
    err_clr = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    k = -1;
    guard = 0;
    ew = 0;
    while (busy && guard < 200) begin
      if (unit_start != 0) k++;
      unit_done = (unit_start != 0 && k == lat) ? sel : 4'b0;
      if (noise)
        unit_done = unit_done |
          ((k == lat) ? ~sel : (4'($urandom) & ~sel));
      err_clr = 1'b0;
      if (err) begin
        ew++;
        if (ew > cd) err_clr = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("instr_completion_bound", 64'(guard), 64'(0));
    unit_done = '0;
    err_clr = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      err_clr = 1'($urandom);
      unit_done = 4'($urandom);
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
    unit_done = '0;
  endtask

  int s_start, s_abort, s_retire, s_err, s_bad;

  task automatic snap();
    s_start  = tot_start;
    s_abort  = tot_abort;
    s_retire = tot_retire;
    s_err    = tot_err;
    s_bad    = tot_bad;
  endtask

  initial begin
    #2 rst = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(instr_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cnt", 64'(retired_cnt), 64'(0));
    check("rst_params", 64'({parameter1, parameter2}), 64'(0));
    check("rst_start", 64'({unit_start, bus_grant, unit_abort}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(instr_ready), 64'(1));

    // ALU immediate, done 6 cycles after start
    snap();
    do_instr(16'h1043, 6, 1'b0);
    check("r38_start_cycles", 64'(tot_start - s_start), 64'(7));
    check("r38_start_sel", 64'(last_start), 64'(4'b0010));
    check("r38_retire", 64'(tot_retire - s_retire), 64'(1));
    check("r38_cnt", 64'(retired_cnt), 64'(1));
    check("r38_p1", 64'(parameter1), 64'(6'h01));
    check("r38_p2", 64'(parameter2), 64'(6'h03));

    // illegal opcode
    snap();
    do_instr(16'h7000, NEVER, 1'b0);
    check("r39_err_seen", 64'(tot_err - s_err > 0), 64'(1));
    check("r39_no_start", 64'(tot_start - s_start), 64'(0));
    check("r39_no_abort", 64'(tot_abort - s_abort), 64'(0));
    check("r39_ready", 64'(instr_ready), 64'(1));

    // unit2 never completes
    snap();
    do_instr(16'h2000, NEVER, 1'b0);
    check("r40_start_cycles", 64'(tot_start - s_start), 64'(1 + TO));
    check("r40_abort_cycles", 64'(tot_abort - s_abort), 64'(1));
    check("r40_abort_sel", 64'(last_abort), 64'(4'b0100));
    check("r40_abort_alone", 64'(tot_bad - s_bad), 64'(0));
    check("r40_err_seen", 64'(tot_err - s_err > 0), 64'(1));
    check("r40_no_retire", 64'(tot_retire - s_retire), 64'(0));

    // unit0 done on the timeout cycle, other units also pulse
    snap();
    do_instr(16'h0000, TO, 1'b1);
    check("r41_retire", 64'(tot_retire - s_retire), 64'(1));
    check("r41_no_err", 64'(tot_err - s_err), 64'(0));
    check("r41_no_abort", 64'(tot_abort - s_abort), 64'(0));
    check("r41_cnt", 64'(retired_cnt), 64'(2));

    // 256 back-to-back legal instructions wrap the counter
    for (int i = 0; i < 256; i++)
      do_instr({2'b00, 2'($urandom), 12'($urandom)},
               $urandom_range(1, 3), 1'b0);
    check("wrap_cnt", 64'(retired_cnt), 64'(2));

    // random traffic
    for (int i = 0; i < 120; i++) begin
      logic [3:0] op;
      int lat;
      op = ($urandom_range(0, 99) < 70) ? 4'($urandom_range(0, 3))
                                         : 4'($urandom_range(4, 15));
      lat = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 36);
      do_instr({op, 12'($urandom)}, lat, 1'($urandom));
      idle_gap($urandom_range(0, 2));
    end

    // asynchronous reset in the middle of WAIT
    snap();
    instr_valid = 1'b1;
    instr = 16'h3ABC;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("mid_wait_start", 64'(unit_start), 64'(4'b1000));
    rst = 1'b0;
    #1;
    check("async_start", 64'({unit_start, bus_grant}), 64'(0));
    check("async_abort", 64'(unit_abort), 64'(0));
    check("async_busy", 64'({busy, err, retire}), 64'(0));
    check("async_cnt", 64'(retired_cnt), 64'(0));
    check("async_params", 64'({parameter1, parameter2}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_no_abort", 64'(tot_abort - s_abort), 64'(0));
    check("ready_after_rst2", 64'(instr_ready), 64'(1));
    do_instr(16'h1FFF, 2, 1'b0);
    check("post_rst_cnt", 64'(retired_cnt), 64'(1));
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
